// File: rtl/seq_alu.sv
// Sequential ALU: one-cycle basic ops, plus iterative one-bit-per-cycle multiply/divide.
// Define SEQ_ALU_MULDIV_EN to build the mul/div datapath; without it mul/div ops complete as illegal.
module seq_alu #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [4:0]            op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0] hi,
  output logic                  overflow,
  output logic                  carryout,
  output logic                  zero,
  output logic                  div_zero,
  output logic                  illegal
);

  localparam int unsigned W = DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [W-1:0] result;
    logic [W-1:0] hi;
    logic         overflow;
    logic         carryout;
    logic         zero;
    logic         div_zero;
    logic         illegal;
  } res_t;

  state_e       state_q, state_d;
  logic         out_valid_q, out_valid_d;
  res_t         res_q, res_d;
  res_t         basic_res;
  logic         xfer;
  logic         md_op;
  logic         is_sub;
  logic [W:0]   sum;
  logic [SHAMT_W-1:0] shamt;

  // in_ready is the only output allowed to follow out_ready combinationally
  assign in_ready = resetn & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
  assign xfer     = in_valid & in_ready;

  // Single-cycle operations; any op[4]=1 lands here only when mul/div is not built
  always_comb begin
    basic_res = '0;
    is_sub    = (op[3:0] == 4'b1010);
    shamt     = B[SHAMT_W-1:0];
    sum       = {1'b0, A} + {1'b0, (is_sub ? ~B : B)} + (W+1)'(is_sub);
    if (!op[4]) begin
      case (op[3:0])
        4'b0000: basic_res.result = A & B;
        4'b0001: basic_res.result = A | B;
        4'b0011: basic_res.result = ~(A | B);
        4'b0101: basic_res.result = A ^ B;
        4'b0100: basic_res.result = A << shamt;
        4'b0110: basic_res.result = A >> shamt;
        4'b0111: basic_res.result = W'($signed(A) >>> shamt);
        4'b0010, 4'b1010: begin
          basic_res.result   = sum[W-1:0];
          basic_res.carryout = is_sub ? ~sum[W] : sum[W];
          basic_res.overflow = ((A[W-1] ^ B[W-1]) == is_sub) & (sum[W-1] != A[W-1]);
        end
        4'b1011: basic_res.result = W'($signed(A) < $signed(B));
        4'b1111: basic_res.result = W'(A < B);
        default: basic_res.illegal = 1'b1;
      endcase
    end else begin
      basic_res.illegal = 1'b1;
    end
    basic_res.zero = (basic_res.result == '0);
  end

`ifdef SEQ_ALU_MULDIV_EN
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

  logic [W-1:0]     wk_hi_q, wk_hi_d, wk_lo_q, wk_lo_d, dvs_q, dvs_d, a_q, a_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d, ovf_q, ovf_d;
  logic             a_neg, b_neg;
  logic [W-1:0]     a_mag, b_mag, step_hi, step_lo;
  logic [W:0]       mul_sum, div_shift;
  logic [2*W-1:0]   prod;
  res_t             md_res;

  assign md_op = op[4];

  // Magnitude shift-add multiply / restoring divide; signs are applied on the final step
  always_comb begin
    a_neg     = ~op[0] & A[W-1];
    b_neg     = ~op[0] & B[W-1];
    a_mag     = a_neg ? -A : A;
    b_mag     = b_neg ? -B : B;
    mul_sum   = {1'b0, wk_hi_q} + (wk_lo_q[0] ? {1'b0, dvs_q} : '0);
    div_shift = {wk_hi_q, wk_lo_q[W-1]};
    if (is_div_q) begin
      if (div_shift >= {1'b0, dvs_q}) begin
        step_hi = W'(div_shift - {1'b0, dvs_q});
        step_lo = {wk_lo_q[W-2:0], 1'b1};
      end else begin
        step_hi = div_shift[W-1:0];
        step_lo = {wk_lo_q[W-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[W:1];
      step_lo = {mul_sum[0], wk_lo_q[W-1:1]};
    end
    prod = neg_res_q ? -{step_hi, step_lo} : {step_hi, step_lo};

    md_res = '0;
    if (is_div_q) begin
      if (dz_q) begin
        md_res.result   = '1;
        md_res.hi       = a_q;
        md_res.div_zero = 1'b1;
      end else begin
        md_res.result   = neg_res_q ? -step_lo : step_lo;
        md_res.hi       = neg_rem_q ? -step_hi : step_hi;
        md_res.overflow = ovf_q;
      end
    end else begin
      md_res.result = prod[W-1:0];
      md_res.hi     = prod[2*W-1:W];
    end
    md_res.zero = (md_res.result == '0);

    wk_hi_d   = wk_hi_q;
    wk_lo_d   = wk_lo_q;
    dvs_d     = dvs_q;
    a_d       = a_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;
    if (xfer && md_op) begin
      wk_hi_d   = '0;
      wk_lo_d   = a_mag;
      dvs_d     = b_mag;
      a_d       = A;
      cnt_d     = '0;
      is_div_d  = op[1];
      neg_res_d = a_neg ^ b_neg;
      neg_rem_d = a_neg;
      dz_d      = op[1] & (B == '0);
      ovf_d     = op[1] & ~op[0] & (A == {1'b1, {(W-1){1'b0}}}) & (B == '1);
    end else if (state_q == S_BUSY) begin
      wk_hi_d = step_hi;
      wk_lo_d = step_lo;
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end
`else
  assign md_op = 1'b0;
`endif

  // Control: accept, iterate, hold result until consumed
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (xfer) begin
          if (md_op) begin
            state_d     = S_BUSY;
            out_valid_d = 1'b0;
          end else begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            res_d       = basic_res;
          end
        end else if ((state_q == S_DONE) && out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
`ifdef SEQ_ALU_MULDIV_EN
      S_BUSY: begin
        if (cnt_q == CNT_W'(W-1)) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          res_d       = md_res;
        end
      end
`endif
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      res_q       <= '0;
`ifdef SEQ_ALU_MULDIV_EN
      wk_hi_q     <= '0;
      wk_lo_q     <= '0;
      dvs_q       <= '0;
      a_q         <= '0;
      cnt_q       <= '0;
      is_div_q    <= 1'b0;
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
`ifdef SEQ_ALU_MULDIV_EN
      wk_hi_q     <= wk_hi_d;
      wk_lo_q     <= wk_lo_d;
      dvs_q       <= dvs_d;
      a_q         <= a_d;
      cnt_q       <= cnt_d;
      is_div_q    <= is_div_d;
      neg_res_q   <= neg_res_d;
      neg_rem_q   <= neg_rem_d;
      dz_q        <= dz_d;
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign result    = res_q.result;
  assign hi        = res_q.hi;
  assign overflow  = res_q.overflow;
  assign carryout  = res_q.carryout;
  assign zero      = res_q.zero;
  assign div_zero  = res_q.div_zero;
  assign illegal   = res_q.illegal;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: transaction-level reference model, per-cycle compare, directed and random stimulus.
module tb_seq_alu;
  localparam int unsigned W = 32;

  localparam logic [4:0] OP_AND = 5'h00, OP_OR = 5'h01, OP_ADD = 5'h02, OP_NOR = 5'h03;
  localparam logic [4:0] OP_SL = 5'h04, OP_XOR = 5'h05, OP_SRL = 5'h06, OP_SRA = 5'h07;
  localparam logic [4:0] OP_SUB = 5'h0A, OP_SLT = 5'h0B, OP_SLTU = 5'h0F;
  localparam logic [4:0] OP_MULT = 5'h10, OP_MULTU = 5'h11, OP_DIV = 5'h12, OP_DIVU = 5'h13;

  logic clk = 1'b0;
  logic resetn, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] A, B, result, hi;
  logic [4:0] op;
  logic overflow, carryout, zero, div_zero, illegal;

  always #5 clk = ~clk;

  seq_alu #(.DATA_WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .hi(hi), .overflow(overflow), .carryout(carryout),
    .zero(zero), .div_zero(div_zero), .illegal(illegal)
  );

  typedef struct packed {
    logic [W-1:0] result;
    logic [W-1:0] hi;
    logic ovf, cout, zero, dz, ill;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  bit   m_valid = 1'b0;
  int   cd = 0;
  exp_t m_res = '0;
  exp_t pend = '0;
  exp_t got_c;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Expected outcome of one operation, straight from the arithmetic definitions
  function automatic exp_t model(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [63:0] w;
    longint s;
    int q, r;
    e = '0;
    if (!o[4]) begin
      case (o[3:0])
        4'h0: e.result = a & b;
        4'h1: e.result = a | b;
        4'h3: e.result = ~(a | b);
        4'h5: e.result = a ^ b;
        4'h4: e.result = a << b[4:0];
        4'h6: e.result = a >> b[4:0];
        4'h7: e.result = 32'($signed(a) >>> b[4:0]);
        4'h2: begin
          w = {32'd0, a} + {32'd0, b};
          e.result = w[31:0];
          e.cout = w[32];
          s = longint'($signed(a)) + longint'($signed(b));
          e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        4'hA: begin
          e.result = a - b;
          e.cout = (a < b);
          s = longint'($signed(a)) - longint'($signed(b));
          e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        4'hB: e.result = {31'd0, ($signed(a) < $signed(b))};
        4'hF: e.result = {31'd0, (a < b)};
        default: e.ill = 1'b1;
      endcase
    end else begin
`ifdef SEQ_ALU_MULDIV_EN
      case (o[1:0])
        2'd0: begin
          s = longint'($signed(a)) * longint'($signed(b));
          w = 64'(s);
          {e.hi, e.result} = w;
        end
        2'd1: begin
          w = {32'd0, a} * {32'd0, b};
          {e.hi, e.result} = w;
        end
        2'd2: begin
          if (b == 0) begin
            e.result = '1; e.hi = a; e.dz = 1'b1;
          end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.result = a; e.hi = '0; e.ovf = 1'b1;
          end else begin
            q = int'($signed(a)) / int'($signed(b));
            r = int'($signed(a)) % int'($signed(b));
            e.result = 32'(q); e.hi = 32'(r);
          end
        end
        default: begin
          if (b == 0) begin
            e.result = '1; e.hi = a; e.dz = 1'b1;
          end else begin
            e.result = a / b; e.hi = a % b;
          end
        end
      endcase
`else
      e.ill = 1'b1;
`endif
    end
    e.zero = (e.result == 0);
    return e;
  endfunction

  // Advance the transaction model across one rising edge
  task automatic model_edge(input bit iv, input logic [4:0] o, input logic [W-1:0] a,
                            input logic [W-1:0] b, input bit ordy);
    bit rdy;
    int lat;
    rdy = (cd == 0) && (!m_valid || ordy);
    lat = 1;
`ifdef SEQ_ALU_MULDIV_EN
    if (o[4]) lat = W + 1;
`endif
    if (iv && rdy) begin
      if (lat == 1) begin
        m_valid = 1'b1; m_res = model(o, a, b);
      end else begin
        m_valid = 1'b0; cd = lat - 1; pend = model(o, a, b);
      end
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        m_valid = 1'b1; m_res = pend;
      end
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic step(input bit iv, input logic [4:0] o, input logic [W-1:0] a,
                      input logic [W-1:0] b, input bit ordy);
    in_valid = iv; op = o; A = a; B = b; out_ready = ordy;
    @(posedge clk);
    model_edge(iv, o, a, b, ordy);
    #1;
  endtask

  // Issue one op and wait (bounded) for its result
  task automatic run_op(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit ordy, output int n);
    step(1'b1, o, a, b, 1'b1);
    n = 1;
    while (!out_valid && n < 64) begin
      step(1'b0, o, a, b, ordy);
      n++;
    end
    chk("run_op_done", out_valid, 1);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      chk("out_valid", out_valid, m_valid);
      chk("in_ready", in_ready, (cd == 0) && (!m_valid || out_ready));
      if (m_valid) begin
        got_c = {result, hi, overflow, carryout, zero, div_zero, illegal};
        checks++;
        if (got_c !== m_res) begin
          errors++;
          $display("FAIL result_bundle got=%h exp=%h", got_c, m_res);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [4:0] ops [17];
    int n;
    ops = '{OP_AND, OP_OR, OP_ADD, OP_NOR, OP_SL, OP_XOR, OP_SRL, OP_SRA, OP_SUB, OP_SLT,
            OP_SLTU, 5'h08, 5'h0C, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    resetn = 1'b0; in_valid = 1'b0; A = '0; B = '0; op = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_hi", hi, 0);
    chk("rst_flags", {overflow, carryout, zero, div_zero, illegal}, 0);
    resetn = 1'b1;

    step(1'b1, OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b1);
    chk("add_valid", out_valid, 1);
    chk("add_result", result, 64'h8000_0000);
    chk("add_ovf", overflow, 1);
    chk("add_cout", carryout, 0);
    step(1'b1, OP_SUB, 32'h0, 32'h1, 1'b1);
    chk("sub_result", result, 64'hFFFF_FFFF);
    chk("sub_cout", carryout, 1);
    chk("sub_ovf", overflow, 0);
    step(1'b1, OP_SLT, 32'hFFFF_FFFF, 32'h1, 1'b1);
    chk("slt_result", result, 1);
    step(1'b1, OP_SLTU, 32'hFFFF_FFFF, 32'h1, 1'b1);
    chk("sltu_result", result, 0);
    step(1'b1, OP_SRA, 32'h8000_00F0, 32'h24, 1'b1);
    chk("sra_result", result, 64'hF800_000F);
    step(1'b0, OP_ADD, 0, 0, 1'b1);

`ifdef SEQ_ALU_MULDIV_EN
    step(1'b1, OP_MULT, 32'hFFFF_FFFE, 32'h3, 1'b1);
    n = 1;
    while (!out_valid && n < 64) begin
      chk("busy_in_ready", in_ready, 0);
      step(1'b1, OP_MULT, 32'hFFFF_FFFE, 32'h3, 1'b1);
      n++;
    end
    chk("mult_latency", n, W + 1);
    chk("mult_prod", {hi, result}, 64'hFFFF_FFFF_FFFF_FFFA);
    step(1'b0, OP_ADD, 0, 0, 1'b1);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'h2, 1'b1, n);
    chk("div_q", result, 64'hFFFF_FFFD);
    chk("div_r", hi, 64'hFFFF_FFFF);
    step(1'b0, OP_ADD, 0, 0, 1'b1);
    run_op(OP_DIVU, 32'h5, 32'h0, 1'b1, n);
    chk("divz_result", {result, hi}, 64'hFFFF_FFFF_0000_0005);
    chk("divz_flag", div_zero, 1);
    step(1'b0, OP_ADD, 0, 0, 1'b1);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, n);
    chk("divmin_result", {result, hi}, 64'h8000_0000_0000_0000);
    chk("divmin_ovf", overflow, 1);
    step(1'b0, OP_ADD, 0, 0, 1'b1);
`else
    run_op(OP_MULT, 32'hFFFF_FFFE, 32'h3, 1'b1, n);
    chk("mult_off_latency", n, 1);
    chk("mult_off_result", {result, hi}, 0);
    chk("mult_off_illegal", illegal, 1);
    step(1'b0, OP_ADD, 0, 0, 1'b1);
`endif

    run_op(OP_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, n);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, OP_AND, 32'h1234_5678, 32'h0, 1'b0);
      chk("hold_valid", out_valid, 1);
      chk("hold_result", result, 64'hFF00_FF00);
    end
    in_valid = 1'b1; op = OP_ADD; A = 32'd2; B = 32'd3; out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", in_ready, 1);
    step(1'b1, OP_ADD, 32'd2, 32'd3, 1'b1);
    chk("b2b_valid", out_valid, 1);
    chk("b2b_result", result, 5);
    step(1'b0, OP_ADD, 0, 0, 1'b1);

    step(1'b1, OP_DIV, 32'd100, 32'd7, 1'b0);
    repeat (9) step(1'b0, OP_ADD, 0, 0, 1'b0);
    resetn = 1'b0;
    m_valid = 1'b0; cd = 0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_result", {result, hi}, 0);
    chk("abort_flags", {overflow, carryout, zero, div_zero, illegal}, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    step(1'b1, OP_ADD, 32'd2, 32'd3, 1'b1);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_result", result, 5);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 2) != 0, ops[$urandom_range(0, 16)], pick(), pick(),
           $urandom_range(0, 3) != 0);
    end
    step(1'b0, OP_ADD, 0, 0, 1'b1);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand/result width; SHALL be even and >= 8.
REQ-002 Parameter SHAMT_W, default $clog2(DATA_WIDTH): number of B LSBs used as the shift amount.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port resetn, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port in_valid, input, 1: the operation on A/B/op is offered.
REQ-006 Port in_ready, output, 1: the block can accept an operation this cycle.
REQ-007 Ports A and B, input, DATA_WIDTH each: operands.
REQ-008 Port op, input, 5: op[4]=0 selects op[3:0] = AND 0000, OR 0001, ADD 0010, NOR 0011, SL 0100, XOR 0101, SRL 0110, SRA 0111, SUB 1010, SLT 1011, SLTU 1111; op[4]=1 selects op[1:0] = MULT 00, MULTU 01, DIV 10, DIVU 11.
REQ-009 Port out_valid, output, 1: the result registers hold a completed result.
REQ-010 Port out_ready, input, 1: the consumer takes the result.
REQ-011 Ports result and hi, output, DATA_WIDTH each: low word / quotient, and high word / remainder.
REQ-012 Ports overflow, carryout, zero, div_zero, illegal, output, 1 each: result flags.

Function
REQ-013 A transfer SHALL occur on any edge where in_valid and in_ready are both 1; operands and op SHALL be captured at that edge.
REQ-014 FSM states SHALL be IDLE, BUSY and DONE; reset SHALL enter IDLE.
REQ-015 in_ready SHALL be 1 in IDLE and in DONE while out_ready=1, and 0 otherwise.
REQ-016 A basic op (op[4]=0) SHALL go to DONE one cycle after the transfer, with out_valid=1.
REQ-017 A mul/div op SHALL go to BUSY, iterate one bit per cycle for exactly DATA_WIDTH cycles, then go to DONE.
- Latency is DATA_WIDTH+1 cycles from transfer to out_valid.
REQ-018 In DONE, out_valid and all result outputs SHALL hold stable until out_ready=1.
- If out_ready and in_valid are both 1, the new operation SHALL be accepted in the same cycle (back-to-back).
- Otherwise the FSM SHALL return to IDLE and out_valid SHALL go to 0.
REQ-019 Basic-op arithmetic:
- ADD/SUB: {carry, sum} = A + (B or ~B) + sub.
- SUB carryout SHALL be the inverted carry (borrow).
- overflow SHALL follow signed rules for ADD and SUB only; it SHALL be 0 for all other ops.
REQ-020 Logic and compare ops:
- NOR = ~(A|B).
- SLT = signed A<B; SLTU = unsigned A<B; both zero-extended to DATA_WIDTH.
REQ-021 Shifts SHALL use B[SHAMT_W-1:0] only; SRA SHALL replicate A[DATA_WIDTH-1].
REQ-022 For every op, hi SHALL be 0 for basic ops and zero SHALL be 1 iff result is 0.
REQ-023 MULT/MULTU SHALL produce the 2*DATA_WIDTH product, signed or unsigned, as {hi, result}.
REQ-024 DIV/DIVU SHALL give result = quotient and hi = remainder.
- Signed quotient truncates toward zero; the remainder takes the sign of A.
REQ-025 Divide by zero (B=0): result = all ones, hi = A, div_zero = 1; otherwise div_zero = 0.
REQ-026 Signed DIV of the most negative value by -1: result = most negative value, hi = 0, overflow = 1.
REQ-027 An op[4]=0 code not listed in REQ-008 SHALL complete in one cycle with result = 0 and illegal = 1.
REQ-028 All outputs SHALL be registered; none SHALL depend combinationally on A, B or op.
- in_ready may depend on out_ready.

Reset
REQ-029 While resetn=0, the FSM SHALL be in IDLE; in_ready, out_valid, result, hi and all flags SHALL be 0.
REQ-030 Reset asserted in BUSY or DONE SHALL abort and discard the operation with no partial output.
- The first transfer SHALL be possible on the first edge after resetn rises.

Configuration
REQ-031 Macro SEQ_ALU_MULDIV_EN defined: the mul/div datapath and the BUSY state SHALL be present as specified.
REQ-032 Macro SEQ_ALU_MULDIV_EN undefined:
- Any op[4]=1 SHALL complete in one cycle with result = 0, hi = 0, illegal = 1.
- No multiply or divide logic SHALL be instantiated.

Verification (DATA_WIDTH=32)
REQ-033 ADD A=7FFFFFFF, B=1 -> result=80000000, overflow=1, carryout=0, out_valid on the cycle after transfer.
REQ-034 SUB A=0, B=1 -> result=FFFFFFFF, carryout=1, overflow=0; SLT A=FFFFFFFF, B=1 -> result 1; SLTU with the same operands -> result 0.
REQ-035 MULT A=FFFFFFFE, B=3 -> {hi, result} = FFFFFFFF_FFFFFFFA, out_valid exactly 33 cycles after transfer; in_ready=0 throughout BUSY.
REQ-036 DIV A=FFFFFFF9 (-7), B=2 -> result=FFFFFFFD, hi=FFFFFFFF; DIVU A=5, B=0 -> result=FFFFFFFF, hi=5, div_zero=1.
REQ-037 out_ready held 0 for 5 cycles in DONE -> outputs stable throughout; then out_ready=1 together with in_valid=1 -> new op accepted on the same edge.
REQ-038 resetn pulsed low at cycle 10 of a DIV -> all outputs 0 immediately; the next ADD 2+3 -> result 5.
